spi_byte_slave: RTL and testbench



---
 rtl/spi_byte_slave.sv | 129 ++++++++++++
 tb/tb_spi_byte_slave.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/spi_byte_slave.sv
// spi_byte_slave: oversampled SPI mode-0 byte slave with per-byte strobes and posted transmit byte
module spi_byte_slave #(
  parameter logic [7:0] FILL_BYTE     = 8'hFF,
  parameter bit         MISO_TRISTATE = 1'b1
) (
  input  logic       clock_50,
  input  logic       reset,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       ss,
  output logic       miso,
  output logic       byte_received,
  output logic [7:0] byte_data_received,
  input  logic [7:0] byte_send,
  input  logic       send_latch,
  output logic       frame_start,
  output logic       frame_end,
  output logic       frame_abort,
  output logic       tx_underrun
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t     state_q, state_d;
  logic [2:0] sclk_q, ss_q;
  logic [1:0] mosi_q;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] rx_q, rx_d, tx_q, tx_d, data_q, data_d;
  logic       done_q, done_d;
  logic       rcv_q, rcv_d, start_q, start_d, end_q, end_d, abort_q, abort_d, und_q, und_d;
  logic       sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic [7:0] load_byte;
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign ss_fall   = ~ss_q[1] & ss_q[2];
  assign ss_rise   = ss_q[1] & ~ss_q[2];
  assign load_byte = send_latch ? byte_send : FILL_BYTE;
  assign miso               = (state_q == ACTIVE) ? tx_q[7] : (MISO_TRISTATE ? 1'bz : 1'b1);
  assign byte_received      = rcv_q;
  assign byte_data_received = data_q;
  assign frame_start        = start_q;
  assign frame_end          = end_q;
  assign frame_abort        = abort_q;
  assign tx_underrun        = und_q;
  // Pin synchronizers; sync regs reset to 0 so a select already low after reset is not seen as a new frame
  always_ff @(posedge clock_50) begin
    if (reset) begin
      sclk_q <= '0;
      ss_q   <= '0;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      ss_q   <= {ss_q[1:0], ss};
      mosi_q <= {mosi_q[0], mosi};
    end
  end
  // Frame/shift state registers
  always_ff @(posedge clock_50) begin
    if (reset) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      rx_q     <= '0;
      tx_q     <= FILL_BYTE;
      data_q   <= '0;
      done_q   <= 1'b0;
      rcv_q    <= 1'b0;
      start_q  <= 1'b0;
      end_q    <= 1'b0;
      abort_q  <= 1'b0;
      und_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
      data_q   <= data_d;
      done_q   <= done_d;
      rcv_q    <= rcv_d;
      start_q  <= start_d;
      end_q    <= end_d;
      abort_q  <= abort_d;
      und_q    <= und_d;
    end
  end
  // Next-state: select edges frame the transfer, sclk rise samples mosi, sclk fall advances miso
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    data_d   = data_q;
    done_d   = done_q;
    rcv_d    = 1'b0;
    start_d  = 1'b0;
    end_d    = 1'b0;
    abort_d  = 1'b0;
    und_d    = 1'b0;
    if (state_q == IDLE) begin
      if (ss_fall) begin
        state_d  = ACTIVE;
        start_d  = 1'b1;
        bitcnt_d = '0;
        rx_d     = '0;
        done_d   = 1'b0;
        tx_d     = load_byte;
        und_d    = ~send_latch;
      end
    end else if (ss_rise) begin
      state_d  = IDLE;
      end_d    = 1'b1;
      abort_d  = bitcnt_q != 3'd0;
      bitcnt_d = '0;
      rx_d     = '0;
    end else if (sclk_rise) begin
      rx_d     = {rx_q[6:0], mosi_q[1]};
      bitcnt_d = bitcnt_q + 3'd1;
      if (bitcnt_q == 3'd7) begin
        data_d = {rx_q[6:0], mosi_q[1]};
        rcv_d  = 1'b1;
        done_d = 1'b1;
      end
    end else if (sclk_fall) begin
      if (bitcnt_q != 3'd0) begin
        tx_d = {tx_q[6:0], 1'b0};
      end else if (done_q) begin
        tx_d  = load_byte;
        und_d = ~send_latch;
      end
    end
  end
endmodule

// File: tb/tb_spi_byte_slave.sv
// tb_spi_byte_slave: time-based SPI master with byte scoreboard for spi_byte_slave
module tb_spi_byte_slave;
  logic       clk = 1'b0, reset = 1'b1, sclk = 1'b0, mosi = 1'b0, ss = 1'b1;
  logic [7:0] byte_send = 8'h00;
  logic       send_latch = 1'b0;
  wire        miso;
  logic       byte_received, frame_start, frame_end, frame_abort, tx_underrun;
  logic [7:0] byte_data_received;
  int n_chk = 0, n_pass = 0;
  int n_rcv = 0, n_start = 0, n_end = 0, n_abort = 0, n_und = 0;
  int b_rcv, b_start, b_end, b_abort, b_und;
  logic [7:0] exp_rx[$];
  logic [7:0] mbytes[$];
  logic [7:0] cap[$];
  logic [7:0] prev;
  spi_byte_slave #(.FILL_BYTE(8'hFF), .MISO_TRISTATE(1'b0)) dut (
    .clock_50(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .ss(ss), .miso(miso),
    .byte_received(byte_received), .byte_data_received(byte_data_received),
    .byte_send(byte_send), .send_latch(send_latch), .frame_start(frame_start),
    .frame_end(frame_end), .frame_abort(frame_abort), .tx_underrun(tx_underrun)
  );
  always #10 clk = ~clk;
  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction
  task automatic snap();
    b_rcv = n_rcv; b_start = n_start; b_end = n_end; b_abort = n_abort; b_und = n_und;
  endtask
  // Master: sends nbits from mbytes MSB first; last sclk fall coincides with ss rise unless hold
  task automatic frame(input int nbits, input int half, input bit hold);
    logic [7:0] b, c;
    c = '0;
    cap.delete();
    for (int k = 0; k < nbits / 8; k++) exp_rx.push_back(mbytes[k]);
    #($urandom_range(0, 19));
    ss = 1'b0;
    #(2 * half);
    for (int i = 0; i < nbits; i++) begin
      b = mbytes[i / 8];
      mosi = b[7 - (i % 8)];
      #half;
      sclk = 1'b1;
      c = {c[6:0], miso};
      if (i % 8 == 7) cap.push_back(c);
      #half;
      if (i == nbits - 1 && !hold) ss = 1'b1;
      sclk = 1'b0;
    end
    #(8 * half);
    repeat (4) @(negedge clk);
  endtask
  // Monitor: pops the expected byte on every strobe and tallies the other strobes
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (byte_received) begin
        n_rcv++;
        if (exp_rx.size() == 0) check("extra_strobe", 1, 0);
        else check("rx_byte", byte_data_received, exp_rx.pop_front());
      end
      if (frame_abort) check("abort_with_end", frame_end, 1);
      n_start += int'(frame_start);
      n_end   += int'(frame_end);
      n_abort += int'(frame_abort);
      n_und   += int'(tx_underrun);
    end
  end
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    check("rst_strobes", {byte_received, frame_start, frame_end, frame_abort, tx_underrun}, 0);
    check("rst_data", byte_data_received, 8'h00);
    check("rst_miso", miso, 1'b1);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    // single byte
    snap();
    send_latch = 1'b1; byte_send = 8'h3C;
    mbytes = {8'h01};
    frame(8, 125, 1'b0);
    check("single_rcv", n_rcv - b_rcv, 1);
    check("single_start", n_start - b_start, 1);
    check("single_end", n_end - b_end, 1);
    check("single_abort", n_abort - b_abort, 0);
    check("single_und", n_und - b_und, 0);
    check("single_tx", cap[0], 8'h3C);
    check("single_data", byte_data_received, 8'h01);
    // multi-byte with send byte updated after each strobe
    snap();
    byte_send = 8'h55;
    mbytes = {8'h01, 8'h12, 8'h34};
    fork
      frame(24, 125, 1'b0);
      begin
        for (int k = 0; k < 2; k++) begin
          int t;
          t = 0;
          do begin @(negedge clk); t++; end while (!byte_received && t < 3000);
          byte_send = (k == 0) ? 8'hAA : 8'h0F;
        end
      end
    join
    check("multi_rcv", n_rcv - b_rcv, 3);
    check("multi_tx0", cap[0], 8'h55);
    check("multi_tx1", cap[1], 8'hAA);
    check("multi_tx2", cap[2], 8'h0F);
    // underrun
    snap();
    send_latch = 1'b0;
    mbytes = {8'hC3};
    frame(8, 125, 1'b0);
    check("und_count", n_und - b_und, 1);
    check("und_tx", cap[0], 8'hFF);
    // abort after 5 bits, then a clean frame
    snap();
    prev = byte_data_received;
    mbytes = {8'hF0};
    frame(5, 125, 1'b0);
    check("abort_end", n_end - b_end, 1);
    check("abort_abort", n_abort - b_abort, 1);
    check("abort_rcv", n_rcv - b_rcv, 0);
    check("abort_data", byte_data_received, prev);
    snap();
    mbytes = {8'h6B};
    frame(8, 125, 1'b0);
    check("post_abort_rcv", n_rcv - b_rcv, 1);
    check("post_abort_data", byte_data_received, 8'h6B);
    // reset mid-frame after 3 bits
    mbytes = {8'hE7};
    frame(3, 125, 1'b1);
    snap();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midrst_strobes", {byte_received, frame_start, frame_end, frame_abort, tx_underrun}, 0);
    check("midrst_data", byte_data_received, 8'h00);
    check("midrst_miso", miso, 1'b1);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    ss = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_no_end", n_end - b_end, 0);
    snap();
    send_latch = 1'b1;
    mbytes = {8'hA5};
    frame(8, 125, 1'b0);
    check("midrst_rcv", n_rcv - b_rcv, 1);
    check("midrst_start", n_start - b_start, 1);
    check("midrst_data_a5", byte_data_received, 8'hA5);
    // randomized frames
    for (int f = 0; f < 4; f++) begin
      int n;
      n = $urandom_range(1, 4);
      send_latch = 1'($urandom_range(0, 1));
      byte_send = 8'($urandom);
      mbytes.delete();
      for (int k = 0; k < n; k++) mbytes.push_back(8'($urandom));
      snap();
      frame(8 * n, 125, 1'b0);
      check("rnd_rcv", n_rcv - b_rcv, n);
      check("rnd_und", n_und - b_und, send_latch ? 0 : n);
      for (int k = 0; k < n; k++)
        check("rnd_tx", (k < cap.size()) ? cap[k] : 8'hxx, send_latch ? byte_send : 8'hFF);
    end
    // max rate: sclk = clk/8, 256 bytes 00..FF
    snap();
    send_latch = 1'b1; byte_send = 8'h5A;
    mbytes.delete();
    for (int k = 0; k < 256; k++) mbytes.push_back(8'(k));
    frame(2048, 80, 1'b0);
    check("max_rcv", n_rcv - b_rcv, 256);
    check("max_cap_count", cap.size(), 256);
    for (int k = 0; k < cap.size(); k++) check("max_tx", cap[k], 8'h5A);
    check("missed_strobes", exp_rx.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
